// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR arbiter: word width, taps, reset seed,
// FSM encoding and the single-step LFSR function.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h1001;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DELIVER
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the requester at i_ptr has highest
// priority, and priority decreases upward from there with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any_req,
    output logic [IDX_W-1:0]   o_winner
);

    int               w_idx;
    logic [IDX_W-1:0] w_idx_n;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_any_req = |i_req;
        o_winner  = '0;
        w_idx     = 0;
        w_idx_n   = '0;
        // Scan from lowest to highest priority so the hit closest to the pointer wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_idx_n = IDX_W'(w_idx);
            if (i_req[w_idx_n]) begin
                o_winner = w_idx_n;
            end
        end
    end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// One shared 16-bit Fibonacci LFSR handed out word-by-word to NUM_REQ
// requesters under round-robin arbitration, with STEPS shifts per word.
module lfsr_rand_arbiter
    import lfsr_pkg::*;
#(
    parameter int                NUM_REQ  = 4,
    parameter int                STEPS    = 4,
    parameter logic [LFSR_W-1:0] RST_SEED = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [LFSR_W-1:0]  rand_data,
    output logic               rand_valid,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_in,
    output logic               busy,
    output logic [LFSR_W-1:0]  lfsr_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(STEPS + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_winner;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [LFSR_W-1:0]  r_rand_data;
    logic               r_rand_valid;
    logic               w_any_req;
    logic [IDX_W-1:0]   w_winner;
    logic               w_last_step;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_any_req (w_any_req),
        .o_winner  (w_winner)
    );

    assign w_last_step = (r_state == STEP) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!seed_load && w_any_req) w_next_state = STEP;
            STEP:    if (w_last_step) w_next_state = DELIVER;
            DELIVER: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr       <= RST_SEED;
            r_ptr        <= '0;
            r_winner     <= '0;
            r_cnt        <= '0;
            r_gnt        <= '0;
            r_rand_valid <= 1'b0;
            r_rand_data  <= '0;
        end else begin
            r_gnt        <= '0;
            r_rand_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= (seed_in == '0) ? RST_SEED : seed_in;
                    end else if (w_any_req) begin
                        r_winner <= w_winner;
                        r_cnt    <= CNT_W'(STEPS);
                    end
                end
                STEP: begin
                    r_lfsr <= lfsr_next(r_lfsr);
                    r_cnt  <= r_cnt - CNT_W'(1);
                    // Register the outputs on the final shift so they appear exactly in DELIVER.
                    if (w_last_step) begin
                        r_gnt[r_winner] <= 1'b1;
                        r_rand_valid    <= 1'b1;
                        r_rand_data     <= lfsr_next(r_lfsr);
                    end
                end
                DELIVER: begin
                    r_ptr <= (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign rand_valid = r_rand_valid;
    assign rand_data  = r_rand_data;
    assign busy       = (r_state != IDLE);
    assign lfsr_state = r_lfsr;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Self-checking bench: directed scenarios plus a random phase, all compared
// against a transaction-level timing model of the shared-LFSR arbiter.
module tb_lfsr_rand_arbiter;

    localparam int          N     = 4;
    localparam int          STEPS = 4;
    localparam logic [15:0] SEED  = 16'h1001;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [15:0]  rand_data;
    logic         rand_valid;
    logic         seed_load;
    logic [15:0]  seed_in;
    logic         busy;
    logic [15:0]  lfsr_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_gnt    = 0;
    int n_valid  = 0;

    lfsr_rand_arbiter #(
        .NUM_REQ  (N),
        .STEPS    (STEPS),
        .RST_SEED (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .rand_data  (rand_data),
        .rand_valid (rand_valid),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy),
        .lfsr_state (lfsr_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word delivered after STEPS shifts; feedback is the parity of the tapped bits.
    function automatic logic [15:0] ref_word(input logic [15:0] s);
        logic [15:0] l;
        l = s;
        for (int i = 0; i < STEPS; i++) l = {l[14:0], ^(l & 16'hB400)};
        return l;
    endfunction

    // Transaction model: edge counter, first edge the arbiter is free, one pending delivery.
    int           cyc = 0;
    int           m_free = 0;
    int           m_ptr = 0;
    int           m_w;
    int           m_deliveries = 0;
    bit           model_on = 1'b0;
    bit           m_pend = 1'b0;
    int           m_pend_time;
    logic [N-1:0] m_pend_gnt;
    logic [15:0]  m_pend_data;
    logic [15:0]  m_lfsr;
    logic [15:0]  m_rand;
    logic [N-1:0] exp_gnt = '0;
    bit           exp_valid = 1'b0;
    bit           exp_busy;

    always @(posedge clk) begin
        cyc++;
        exp_gnt   = '0;
        exp_valid = 1'b0;
        if (reset) begin
            m_lfsr   = SEED;
            m_rand   = 16'h0;
            m_ptr    = 0;
            m_free   = cyc + 1;
            m_pend   = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (m_pend && cyc == m_pend_time) begin
                exp_gnt   = m_pend_gnt;
                exp_valid = 1'b1;
                m_rand    = m_pend_data;
                m_pend    = 1'b0;
                m_deliveries++;
            end
            if (cyc >= m_free) begin
                if (seed_load) begin
                    m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
                end else if (req != '0) begin
                    m_w = -1;
                    for (int i = 0; i < N; i++)
                        if (m_w < 0 && req[2'((m_ptr + i) % N)]) m_w = (m_ptr + i) % N;
                    m_lfsr      = ref_word(m_lfsr);
                    m_pend      = 1'b1;
                    m_pend_time = cyc + STEPS;
                    m_pend_gnt  = N'(1) << m_w;
                    m_pend_data = m_lfsr;
                    m_ptr       = (m_w + 1) % N;
                    m_free      = cyc + STEPS + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (gnt != '0) n_gnt++;
        if (rand_valid) n_valid++;
        if (model_on) begin
            exp_busy = (cyc < m_free - 1);
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("rand_valid", 32'(rand_valid), 32'(exp_valid));
            check("rand_data", 32'(rand_data), 32'(m_rand));
            check("busy", 32'(busy), 32'(exp_busy));
            if (!exp_busy) check("lfsr_state", 32'(lfsr_state), 32'(m_lfsr));
        end
    end

    task automatic wait_gnt(output int lat, output logic [N-1:0] g, output logic [15:0] d);
        lat = 0;
        g   = '0;
        d   = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (gnt != '0) begin
                g = gnt;
                d = rand_data;
                check("valid_with_gnt", 32'(rand_valid), 32'(1));
                return;
            end
        end
        n_checks++;
        assert (gnt != '0) else begin
            n_errors++;
            $error("FAIL gnt_timeout observed=%0h expected=nonzero", gnt);
        end
    endtask

    initial begin
        #300000;
        $error("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    int           lat;
    logic [N-1:0] g;
    logic [15:0]  d;
    int           snap;

    initial begin
        reset     = 1'b1;
        req       = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_valid", 32'(rand_valid), 32'(0));
        check("rst_data", 32'(rand_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_lfsr", 32'(lfsr_state), 32'(SEED));

        // Single requester after reset.
        req = 4'b0001;
        wait_gnt(lat, g, d);
        check("t1_lat", 32'(lat), 32'(5));
        check("t1_gnt", 32'(g), 32'(4'b0001));
        check("t1_data", 32'(d), 32'(ref_word(SEED)));
        req = '0;
        @(negedge clk);
        check("t1_lfsr", 32'(lfsr_state), 32'(ref_word(SEED)));

        // All requesters held: strict rotation, STEPS+2 cycles apart.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(lat, g, d);
            check("t2_gnt", 32'(g), 32'(1) << (k % 4));
            check("t2_gap", 32'(lat), (k == 0) ? 32'(5) : 32'(6));
        end
        req = '0;
        @(negedge clk);

        // Reseed with zero and with a real value.
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        check("t3_seed0", 32'(lfsr_state), 32'(SEED));
        seed_load = 1'b1;
        seed_in   = 16'hACE1;
        @(negedge clk);
        seed_load = 1'b0;
        check("t3_seed", 32'(lfsr_state), 32'(16'hACE1));
        req = 4'b0001;
        wait_gnt(lat, g, d);
        check("t3_data", 32'(d), 32'(ref_word(16'hACE1)));
        req = '0;
        @(negedge clk);

        // Seed and request in the same idle cycle: seed first, request one cycle later.
        seed_load = 1'b1;
        seed_in   = 16'h5A5A;
        req       = 4'b0010;
        @(negedge clk);
        seed_load = 1'b0;
        check("t4_seedfirst", 32'(lfsr_state), 32'(16'h5A5A));
        wait_gnt(lat, g, d);
        check("t4_lat", 32'(lat + 1), 32'(6));
        check("t4_gnt", 32'(g), 32'(4'b0010));
        check("t4_data", 32'(d), 32'(ref_word(16'h5A5A)));
        req = '0;
        @(negedge clk);

        // Seed while busy is dropped.
        req = 4'b0001;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'(1));
        seed_load = 1'b1;
        seed_in   = 16'hBEEF;
        @(negedge clk);
        seed_load = 1'b0;
        wait_gnt(lat, g, d);
        check("t5_lat", 32'(lat + 2), 32'(5));
        check("t5_data", 32'(d), 32'(ref_word(ref_word(16'h5A5A))));
        req = '0;
        @(negedge clk);

        // Reset during STEP aborts the grant and clears the pointer.
        req = 4'b0001;
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rst_lfsr", 32'(lfsr_state), 32'(SEED));
        check("t5_rst_busy", 32'(busy), 32'(0));
        snap = n_gnt;
        repeat (8) @(negedge clk);
        check("t5_no_gnt", 32'(n_gnt), 32'(snap));
        req = 4'b1010;
        wait_gnt(lat, g, d);
        check("t5_ptr0", 32'(g), 32'(4'b0010));
        req = '0;
        @(negedge clk);

        // Request dropped after being latched still completes.
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        wait_gnt(lat, g, d);
        check("t6_gnt", 32'(g), 32'(4'b0100));
        check("t6_lat", 32'(lat + 1), 32'(5));
        @(negedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req       = N'($urandom);
            seed_load = ($urandom_range(0, 7) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            reset     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        req       = '0;
        seed_load = 1'b0;
        reset     = 1'b0;
        repeat (10) @(negedge clk);
        check("valid_vs_gnt", 32'(n_valid), 32'(n_gnt));
        check("gnt_vs_model", 32'(n_gnt), 32'(m_deliveries));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
